// File: rtl/projection_stream_reader.sv
// Read sequencer for the projection memory: sweeps the stored hypervector two words per
// cycle and streams 2*IN_WIDTH-bit chunks through a credit-controlled FIFO.
// Optional feature macro: PROJ_READER_ONES_CNT_EN adds a running popcount of delivered bits.
module projection_stream_reader #(
  parameter int Dhv_SIZE   = 4000,
  parameter int IN_WIDTH   = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    invert,
  input  logic                    proj_ready,
  output logic [ADDR_WIDTH-1:0]   read_address0,
  output logic [ADDR_WIDTH-1:0]   read_address1,
  output logic                    re,
  input  logic [IN_WIDTH-1:0]     out0,
  input  logic [IN_WIDTH-1:0]     out1,
  output logic [2*IN_WIDTH-1:0]   chunk_out,
  output logic [ADDR_WIDTH-1:0]   chunk_index,
  output logic                    chunk_valid,
  input  logic                    chunk_ready,
  output logic                    chunk_last,
  output logic                    busy,
  output logic                    done
`ifdef PROJ_READER_ONES_CNT_EN
  ,
  output logic [$clog2(Dhv_SIZE+1)-1:0] ones_count
`endif
);

  localparam int WORDS = Dhv_SIZE / IN_WIDTH;
  localparam int CW    = 2 * IN_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] raddr0_q, raddr0_d;
  logic [ADDR_WIDTH-1:0] raddr1_q, raddr1_d;
  logic                  inv_q, inv_d;
  logic                  inflight_q, inflight_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [CW-1:0]         data_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] idx_mem  [FIFO_DEPTH];

  logic                  accept, issue, push, pop, fifo_empty, drained;
  logic [CNT_W:0]        occupancy;

  assign accept     = (state_q == S_IDLE) && start && proj_ready;
  // A read issued now lands in the FIFO two edges later, so the previous issue holds a credit.
  assign occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign issue      = (state_q == S_RUN) && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign drained    = fifo_empty && !inflight_q;
  assign push       = inflight_q;
  assign pop        = chunk_valid && chunk_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (issue && (addr_q == LAST_ADDR)) state_d = S_DRAIN;
      S_DRAIN: if (drained) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DRAIN) && drained;
    re            = issue;
    read_address0 = issue ? addr_q : raddr0_q;
    read_address1 = issue ? (addr_q + ADDR_WIDTH'(1)) : raddr1_q;
    chunk_valid   = !fifo_empty;
    // Gating on valid keeps the payload at zero while empty without resetting the storage.
    chunk_out     = chunk_valid ? (data_mem[rd_ptr_q] ^ {CW{inv_q}}) : '0;
    chunk_index   = chunk_valid ? idx_mem[rd_ptr_q] : '0;
    chunk_last    = chunk_valid && (idx_mem[rd_ptr_q] == LAST_ADDR);
  end

  always_comb begin
    addr_d     = addr_q;
    raddr0_d   = raddr0_q;
    raddr1_d   = raddr1_q;
    inv_d      = inv_q;
    inflight_d = issue;
    if (accept) begin
      addr_d = '0;
      inv_d  = invert;
    end else if (issue) begin
      addr_d   = addr_q + ADDR_WIDTH'(2);
      raddr0_d = addr_q;
      raddr1_d = addr_q + ADDR_WIDTH'(1);
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      raddr0_q   <= '0;
      raddr1_q   <= '0;
      inv_q      <= 1'b0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      addr_q     <= addr_d;
      raddr0_q   <= raddr0_d;
      raddr1_q   <= raddr1_d;
      inv_q      <= inv_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= {out1, out0};
      idx_mem[wr_ptr_q]  <= raddr0_q;
    end
  end

`ifdef PROJ_READER_ONES_CNT_EN
  localparam int OW = $clog2(Dhv_SIZE + 1);
  logic [OW-1:0] ones_q, ones_d;

  always_comb begin
    ones_d = ones_q;
    if (accept)   ones_d = '0;
    else if (pop) ones_d = ones_q + OW'($countones(chunk_out));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ones_q <= '0;
    else          ones_q <= ones_d;
  end

  assign ones_count = ones_q;
`endif

endmodule

// File: tb/tb_projection_stream_reader.sv
// Directed bench for projection_stream_reader with a synchronous-read memory model,
// an occupancy model for the credit rule, and per-chunk expected values.
module tb_projection_stream_reader;

  localparam int DHV = 4000;
  localparam int INW = 16;
  localparam int AW  = 8;
  localparam int FD  = 4;
  localparam int NCHUNK = DHV / INW / 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          invert = 1'b0;
  logic          proj_ready = 1'b1;
  logic [AW-1:0] read_address0, read_address1;
  logic          re;
  logic [INW-1:0] out0 = '0, out1 = '0;
  logic [2*INW-1:0] chunk_out;
  logic [AW-1:0] chunk_index;
  logic          chunk_valid;
  logic          chunk_ready = 1'b1;
  logic          chunk_last;
  logic          busy;
  logic          done;
`ifdef PROJ_READER_ONES_CNT_EN
  logic [$clog2(DHV+1)-1:0] ones_count;
`endif

  logic [INW-1:0] mem [256];
  bit fill_ones = 1'b0;
  int errors = 0;
  int checks = 0;

  projection_stream_reader #(
    .Dhv_SIZE(DHV), .IN_WIDTH(INW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .invert(invert), .proj_ready(proj_ready),
    .read_address0(read_address0), .read_address1(read_address1), .re(re),
    .out0(out0), .out1(out1), .chunk_out(chunk_out), .chunk_index(chunk_index),
    .chunk_valid(chunk_valid), .chunk_ready(chunk_ready), .chunk_last(chunk_last),
    .busy(busy), .done(done)
`ifdef PROJ_READER_ONES_CNT_EN
    , .ones_count(ones_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (re) begin
      out0 <= mem[read_address0];
      out1 <= mem[read_address1];
    end
  end

  function automatic logic [31:0] exp_chunk(input int k, input bit inv);
    logic [31:0] d;
    d = fill_ones ? 32'hFFFF_FFFF : {16'(2*k+1), 16'(2*k)};
    return d ^ {32{inv}};
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = fill_ones ? 16'hFFFF : 16'(i);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({re, chunk_valid, chunk_last, busy, done, read_address0, read_address1, chunk_index, chunk_out} !== '0) begin
      errors++;
      $display("FAIL reset_values: got re=%b v=%b l=%b busy=%b done=%b a0=%0d a1=%0d idx=%0d out=%h, expected all zero",
               re, chunk_valid, chunk_last, busy, done, read_address0, read_address1, chunk_index, chunk_out);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || re !== 1'b0 || chunk_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b re=%b valid=%b, expected 0 0 0", busy, re, chunk_valid);
    end
  endtask

  // One sweep observed at negedges; cycle 0 is the interval right after the start edge.
  task automatic run_sweep(input bit inv, input int ready_pct, input int abort_at,
                           input int mid_start_cycle, input string name);
    int  k, cyc, first_valid, done_cyc, last_hs, fifo_m;
    bit  inflight_m, stalled, finished, hs;
    logic [31:0] held_data;
    logic [AW-1:0] held_idx;
    logic held_last;
    k = 0; first_valid = -1; done_cyc = -1; last_hs = -1; fifo_m = 0;
    inflight_m = 0; stalled = 0; finished = 0;
    held_data = '0; held_idx = '0; held_last = 1'b0;

    @(negedge clk);
    start = 1'b1; invert = inv; proj_ready = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (cyc < 2000 && !finished) begin
      start  = (cyc == mid_start_cycle) ? 1'b1 : 1'b0;
      invert = ~inv;
      if (ready_pct < 100 && cyc == 5) proj_ready = 1'b0;
      chunk_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);

      if (cyc == 0) begin
        checks++;
        if (busy !== 1'b1 || re !== 1'b1 || read_address0 !== 8'd0 || read_address1 !== 8'd1) begin
          errors++;
          $display("FAIL %s first_issue: got busy=%b re=%b a0=%0d a1=%0d, expected 1 1 0 1",
                   name, busy, re, read_address0, read_address1);
        end
      end
      if (cyc == 1) begin
        checks++;
        if (re !== 1'b1 || read_address0 !== 8'd2 || read_address1 !== 8'd3) begin
          errors++;
          $display("FAIL %s second_issue: got re=%b a0=%0d a1=%0d, expected 1 2 3",
                   name, re, read_address0, read_address1);
        end
      end
      if (re === 1'b1) begin
        checks++;
        if (fifo_m + int'(inflight_m) >= FD) begin
          errors++;
          $display("FAIL %s credit: re=1 at cycle %0d with occupancy %0d, expected re=0", name, cyc, fifo_m + int'(inflight_m));
        end
      end
      checks++;
      if (chunk_valid !== (fifo_m != 0)) begin
        errors++;
        $display("FAIL %s valid_model cycle %0d: got %b expected %b", name, cyc, chunk_valid, fifo_m != 0);
      end
      if (chunk_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (stalled && chunk_valid === 1'b1) begin
        checks++;
        if (chunk_out !== held_data || chunk_index !== held_idx || chunk_last !== held_last) begin
          errors++;
          $display("FAIL %s stall_stable cycle %0d: got %h/%0d/%b expected %h/%0d/%b",
                   name, cyc, chunk_out, chunk_index, chunk_last, held_data, held_idx, held_last);
        end
      end
      hs = (chunk_valid === 1'b1) && chunk_ready;
      if (hs) begin
        checks++;
        if (chunk_out !== exp_chunk(k, inv) || chunk_index !== AW'(2*k) || chunk_last !== (k == NCHUNK-1)) begin
          errors++;
          $display("FAIL %s chunk[%0d]: got data=%h idx=%0d last=%b expected data=%h idx=%0d last=%b",
                   name, k, chunk_out, chunk_index, chunk_last, exp_chunk(k, inv), 2*k, k == NCHUNK-1);
        end
        k++;
        last_hs = cyc;
        stalled = 1'b0;
      end else if (chunk_valid === 1'b1) begin
        stalled = 1'b1;
        held_data = chunk_out; held_idx = chunk_index; held_last = chunk_last;
      end else begin
        stalled = 1'b0;
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        finished = 1'b1;
`ifdef PROJ_READER_ONES_CNT_EN
        if (fill_ones) begin
          checks++;
          if (ones_count !== (inv ? 12'd0 : 12'd4000)) begin
            errors++;
            $display("FAIL %s ones_count: got %0d expected %0d", name, ones_count, inv ? 0 : 4000);
          end
        end
`endif
      end
      fifo_m = fifo_m + int'(inflight_m) - int'(hs);
      inflight_m = (re === 1'b1);

      if (abort_at > 0 && k == abort_at) begin
        reset_n = 1'b0;
        #1;
        checks++;
        if ({re, chunk_valid, chunk_last, busy, done, read_address0, read_address1, chunk_index, chunk_out} !== '0) begin
          errors++;
          $display("FAIL %s async_reset: got re=%b v=%b l=%b busy=%b done=%b a0=%0d a1=%0d idx=%0d out=%h, expected all zero",
                   name, re, chunk_valid, chunk_last, busy, done, read_address0, read_address1, chunk_index, chunk_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || chunk_valid !== 1'b0 || re !== 1'b0) begin
          errors++;
          $display("FAIL %s after_reset_empty: got busy=%b valid=%b re=%b expected 0 0 0", name, busy, chunk_valid, re);
        end
        chunk_ready = 1'b1;
        return;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; chunk_ready = 1'b1; proj_ready = 1'b1;

    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout: done not seen within %0d cycles, got %0d chunks", name, cyc, k);
      return;
    end
    checks++;
    if (k != NCHUNK) begin
      errors++;
      $display("FAIL %s chunk_count: got %0d expected %0d", name, k, NCHUNK);
    end
    checks++;
    if (first_valid != 2) begin
      errors++;
      $display("FAIL %s first_valid_latency: got %0d expected 2", name, first_valid);
    end
    checks++;
    if (done_cyc != last_hs + 1) begin
      errors++;
      $display("FAIL %s done_timing: got cycle %0d expected %0d", name, done_cyc, last_hs + 1);
    end
    if (ready_pct >= 100) begin
      checks++;
      if (last_hs != 126) begin
        errors++;
        $display("FAIL %s last_chunk_cycle: got %0d expected 126", name, last_hs);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s back_to_idle: got done=%b busy=%b expected 0 0", name, done, busy);
    end
  endtask

  task automatic test_no_proj_ready();
    @(negedge clk);
    start = 1'b1; proj_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || re !== 1'b0) begin
        errors++;
        $display("FAIL no_proj_ready: got busy=%b re=%b expected 0 0", busy, re);
      end
    end
    start = 1'b0; proj_ready = 1'b1;
  endtask

  task automatic test_basic();         run_sweep(1'b0, 100, 0, -1, "basic");     endtask
  task automatic test_invert();        run_sweep(1'b1, 100, 0, -1, "invert");    endtask
  task automatic test_backpressure();  run_sweep(1'b0, 30, 0, -1, "backpress");  endtask
  task automatic test_mid_start();     run_sweep(1'b0, 100, 0, 20, "mid_start"); endtask

  task automatic test_reset_mid_sweep();
    run_sweep(1'b0, 100, 10, -1, "abort");
    run_sweep(1'b0, 100, 0, -1, "replay");
  endtask

`ifdef PROJ_READER_ONES_CNT_EN
  task automatic test_ones_count();
    fill_ones = 1'b1;
    fill_mem();
    run_sweep(1'b0, 100, 0, -1, "ones_pos");
    run_sweep(1'b1, 100, 0, -1, "ones_inv");
    fill_ones = 1'b0;
    fill_mem();
  endtask
`endif

  initial begin
    fill_ones = 1'b0;
    fill_mem();
    test_reset();
    test_basic();
    test_invert();
    test_backpressure();
    test_no_proj_ready();
    test_mid_start();
    test_reset_mid_sweep();
`ifdef PROJ_READER_ONES_CNT_EN
    test_ones_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
